dlx_icache_dm: RTL



---
 rtl/dlx_global_pkg.sv | 14 +
 rtl/dlx_icache_tagmem.sv | 48 ++++
 rtl/dlx_icache_dm.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dlx_global_pkg.sv
// Global DLX types and default widths shared by the instruction cache blocks.
`ifndef IC_BEAT_W
`define IC_BEAT_W 32
`endif

package dlx_global_pkg;
   localparam int unsigned DLX_ADDR_SIZE = 32;
   localparam int unsigned bw_ic_tag     = 7;
   localparam int unsigned bw_ic_offset  = 5;

   typedef logic [`IC_BEAT_W-1:0] dlx_word;

   typedef enum logic [1:0] {IC_IDLE, IC_REFILL, IC_FILL} ic_state;
endpackage

// File: rtl/dlx_icache_tagmem.sv
// Flop-based valid/tag/data arrays: one combinational read port, one write port,
// and a bulk invalidate that overrides a same-cycle write of the valid bit.
module dlx_icache_tagmem
   import dlx_global_pkg::*;
#(
   parameter int unsigned TAG_W   = bw_ic_tag,
   parameter int unsigned INDEX_W = bw_ic_offset,
   parameter int unsigned LINE_W  = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line,
   input  logic               wr_valid,
   input  logic               inval_all
);
   localparam int unsigned LINES = 2 ** INDEX_W;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         if (wr_en) valid_q[wr_idx] <= wr_valid;
         if (inval_all) valid_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/dlx_icache_dm.sv
// Direct-mapped instruction cache with multi-beat refill FSM and flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module dlx_icache_dm
   import dlx_global_pkg::*;
#(
   parameter int unsigned ADDR_W  = DLX_ADDR_SIZE,
   parameter int unsigned TAG_W   = bw_ic_tag,
   parameter int unsigned INDEX_W = bw_ic_offset,
   parameter int unsigned LINE_W  = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic [31:0]           if_rdata,
   output logic                  if_ready,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_rvalid,
   input  logic [`IC_BEAT_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt
`endif
);
   localparam int unsigned WPL     = LINE_W / 32;
   localparam int unsigned WOFF    = $clog2(WPL);
   localparam int unsigned CNT_W   = (WOFF == 0) ? 1 : WOFF;
   localparam int unsigned LSB_IDX = 2 + WOFF;
   localparam int unsigned LSB_TAG = LSB_IDX + INDEX_W;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << LSB_IDX) - 64'd1);

   ic_state             state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [LINE_W-1:0]   buf_q;
   logic                flush_pend_q;
   logic                mem_req_q;
   logic [ADDR_W-1:0]   mem_addr_q;

   logic [INDEX_W-1:0]  lk_idx, fill_idx;
   logic [TAG_W-1:0]    lk_tag, fill_tag, rd_tag;
   logic [CNT_W-1:0]    lk_word;
   logic                rd_valid, lookup_hit, wr_en, inval_all, start_miss;
   logic [LINE_W-1:0]   rd_line;
   logic [31:0]         word_sel;

   // Lookup fields come from the live fetch address; fill fields from the latched line address.
   assign lk_idx   = INDEX_W'(if_addr >> LSB_IDX);
   assign lk_tag   = TAG_W'(if_addr >> LSB_TAG);
   assign lk_word  = (WOFF == 0) ? '0 : CNT_W'(if_addr >> 2);
   assign fill_idx = INDEX_W'(mem_addr_q >> LSB_IDX);
   assign fill_tag = TAG_W'(mem_addr_q >> LSB_TAG);

   dlx_icache_tagmem #(
      .TAG_W   (TAG_W),
      .INDEX_W (INDEX_W),
      .LINE_W  (LINE_W)
   ) u_tagmem (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (lk_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line),
      .wr_en     (wr_en),
      .wr_idx    (fill_idx),
      .wr_tag    (fill_tag),
      .wr_line   (buf_q),
      .wr_valid  (!flush_pend_q),
      .inval_all (inval_all)
   );

   always_comb begin
      word_sel = '0;
      for (int w = 0; w < WPL; w++)
         if (lk_word == CNT_W'(w)) word_sel = rd_line[w*32 +: 32];
   end

   assign lookup_hit = rd_valid && (rd_tag == lk_tag);
   assign if_ready   = (state_q == IC_IDLE) && if_req && lookup_hit;
   assign if_rdata   = if_ready ? word_sel : '0;
   assign start_miss = (state_q == IC_IDLE) && (state_d == IC_REFILL);
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

   always_comb begin
      state_d   = state_q;
      wr_en     = 1'b0;
      inval_all = 1'b0;
      case (state_q)
         IC_IDLE: begin
            inval_all = flush;
            if (if_req && !lookup_hit) state_d = IC_REFILL;
         end
         IC_REFILL: begin
            if (mem_rvalid && (cnt_q == CNT_W'(WPL - 1))) state_d = IC_FILL;
         end
         IC_FILL: begin
            wr_en     = 1'b1;
            inval_all = flush;
            state_d   = IC_IDLE;
         end
         default: state_d = IC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IC_IDLE;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= (state_d == IC_REFILL);
         if (start_miss) mem_addr_q <= if_addr & LINE_MASK;
         if (state_q == IC_REFILL) begin
            if (flush) flush_pend_q <= 1'b1;
            if (mem_rvalid) cnt_q <= cnt_q + CNT_W'(1);
         end
         if (state_q == IC_FILL) begin
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
         end
      end
   end

   // Beats arrive word 0 first; the counter selects the destination word.
   always_ff @(posedge clk) begin
      if ((state_q == IC_REFILL) && mem_rvalid) begin
         for (int w = 0; w < WPL; w++)
            if (cnt_q == CNT_W'(w)) buf_q[w*32 +: 32] <= mem_rdata;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (if_ready && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
         if (start_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif
endmodule
